// File: rtl/spi_frame_pkg.sv
// Shared types and sizing helpers for the SPI register-access frame master.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  // One R/W bit, then address, then data.
  function automatic int frame_len(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles every DIV cycles while enabled, parks at CPOL otherwise.
// lead_o/trail_o flag the cycle whose clock edge makes the corresponding SCLK transition.
module spi_sclk_gen #(
  parameter int DIV  = 2,
  parameter bit CPOL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en_i,
  output logic sclk_o,
  output logic lead_o,
  output logic trail_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  assign tick    = en_i && (cnt_q == CW'(DIV - 1));
  assign lead_o  = tick && (sclk_q == CPOL);
  assign trail_o = tick && (sclk_q != CPOL);
  assign sclk_o  = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = CPOL;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_frame.sv
// SPI master running one R/W + address + data frame per accepted request (CPHA=0).
// All pin outputs are registered; ready is high only in IDLE and extra starts are dropped.
module spi_master_frame
  import spi_frame_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int DIV        = 2,
  parameter bit CPOL       = 1'b0,
  parameter int NUM_CS     = 1,
  localparam int CSW       = cs_width(NUM_CS)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [CSW-1:0]        cs_sel,
  output logic                  ready,
  output logic                  done,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NUM_CS-1:0]     CS_N
);

  localparam int N  = frame_len(ADDR_WIDTH, DATA_WIDTH);
  localparam int BW = $clog2(N + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CSW:0] NUM_CS_W = (CSW + 1)'(NUM_CS);

  state_e                state_q, state_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [N-1:0]          sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rw_q, rw_d;
  logic [CSW-1:0]        cs_q, cs_d;
  logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic accept, cs_ok, accept_ok;
  logic sclk_en, lead, trail, ph_last;

  assign ready     = (state_q == S_IDLE);
  assign accept    = start && ready;
  assign cs_ok     = ({1'b0, cs_sel} < NUM_CS_W);
  assign accept_ok = accept && cs_ok;
  assign sclk_en   = (state_q == S_SETUP) || (state_q == S_SHIFT);
  assign ph_last   = (ph_q == PW'(DIV - 1));

  spi_sclk_gen #(
    .DIV  (DIV),
    .CPOL (CPOL)
  ) u_sclk_gen (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .en_i    (sclk_en),
    .sclk_o  (SCLK),
    .lead_o  (lead),
    .trail_o (trail)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // The first leading edge falls in SETUP; the frame ends on the Nth trailing edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_ok)                state_d = S_SETUP;
      S_SETUP: if (lead)                     state_d = S_SHIFT;
      S_SHIFT: if (trail && bit_q == BW'(N)) state_d = S_HOLD;
      S_HOLD:  if (ph_last)                  state_d = S_GAP;
      S_GAP:   if (ph_last)                  state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // Outputs derived from the next state so the pins change on the same edge as the FSM.
  always_comb begin
    cs_n_d   = '1;
    done_d   = 1'b0;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (cs_d == CSW'(i)) cs_n_d[i] = 1'b0;
      end
    end
    if (state_q == S_GAP && state_d == S_IDLE) begin
      done_d   = 1'b1;
      rvalid_d = rw_q;
    end
    if (accept && !cs_ok) err_d = 1'b1;
  end

  always_comb begin
    ph_d    = '0;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    rdata_d = rdata_q;
    if ((state_q == S_HOLD || state_q == S_GAP) && state_d == state_q)
      ph_d = ph_q + PW'(1);
    if (accept_ok) begin
      bit_d = '0;
      rx_d  = '0;
      rw_d  = rw;
      cs_d  = cs_sel;
      sh_d  = {rw, addr, (rw ? {DATA_WIDTH{1'b0}} : wdata)};
    end else begin
      if (lead) begin
        bit_d = bit_q + BW'(1);
        // MISO matters only for the data phase; bit_q is the index of the bit being sampled.
        if (bit_q >= BW'(1 + ADDR_WIDTH)) rx_d = DATA_WIDTH'({rx_q, MISO});
      end
      if (trail) sh_d = {sh_q[N-2:0], 1'b0};
    end
    if (done_d && rw_q) rdata_d = rx_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ph_q     <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      rx_q     <= '0;
      rw_q     <= 1'b0;
      cs_q     <= '0;
      rdata_q  <= '0;
      cs_n_q   <= '1;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      rw_q     <= rw_d;
      cs_q     <= cs_d;
      rdata_q  <= rdata_d;
      cs_n_q   <= cs_n_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign MOSI   = sh_q[N-1];
  assign CS_N   = cs_n_q;
  assign done   = done_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_spi_master_frame.sv
// Directed bench: default instance (NUM_CS=1, CPOL=0, DIV=2) and a NUM_CS=4, CPOL=1, DIV=1 instance.
module tb_spi_master_frame;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic       start1 = 0, rw1 = 0, miso1 = 0;
  logic [6:0] addr1 = 0;
  logic [7:0] wdata1 = 0;
  logic [0:0] cs1 = 0;
  logic       ready1, done1, rvalid1, err1, sclk1, mosi1;
  logic [7:0] rdata1;
  logic [0:0] cs_n1;

  logic       start4 = 0, rw4 = 0, miso4 = 0;
  logic [6:0] addr4 = 0;
  logic [7:0] wdata4 = 0;
  logic [1:0] cs4 = 0;
  logic       ready4, done4, rvalid4, err4, sclk4, mosi4;
  logic [7:0] rdata4;
  logic [3:0] cs_n4;

  spi_master_frame u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
    .cs_sel(cs1), .ready(ready1), .done(done1), .rvalid(rvalid1), .rdata(rdata1),
    .err(err1), .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .CS_N(cs_n1)
  );

  spi_master_frame #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .DIV(1), .CPOL(1'b1), .NUM_CS(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .start(start4), .rw(rw4), .addr(addr4), .wdata(wdata4),
    .cs_sel(cs4), .ready(ready4), .done(done4), .rvalid(rvalid4), .rdata(rdata4),
    .err(err4), .SCLK(sclk4), .MOSI(mosi4), .MISO(miso4), .CS_N(cs_n4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          res_done_edge, res_n_done, res_cs_first, res_cs_last, res_cs_bad;
  int          res_first_lead, res_n_lead, res_rv_edge;
  logic        res_ready1, res_ready_done;
  logic [15:0] res_mosi;
  logic [7:0]  res_rd;

  // Negedge e (counted from the accepting posedge 0) shows the value "at edge e".
  task automatic run_frame(input bit b, input int div, input int sel, input int nedges,
                           input logic [7:0] rd, input int pulse_e);
    logic       cpol, prev_sclk, s_sclk, s_mosi;
    logic [3:0] s_cs, cs_exp;
    int         k;
    cpol      = b;
    prev_sclk = cpol;
    cs_exp    = ~(4'b0001 << sel);
    res_done_edge = -1; res_n_done = 0; res_cs_first = -1; res_cs_last = -1; res_cs_bad = 0;
    res_first_lead = -1; res_n_lead = 0; res_rv_edge = -1; res_ready1 = 1'bx;
    res_ready_done = 1'bx; res_mosi = '0; res_rd = 'x;
    @(negedge CLK);
    if (b) start4 = 1; else start1 = 1;
    for (int e = 1; e <= nedges; e++) begin
      @(negedge CLK);
      if (b) start4 = 0; else start1 = 0;
      if (e == pulse_e) begin
        start1 = 1; rw1 = 1; addr1 = 7'h7F; wdata1 = 8'hFF;
      end
      s_sclk = b ? sclk4 : sclk1;
      s_mosi = b ? mosi4 : mosi1;
      s_cs   = b ? cs_n4 : {3'b111, cs_n1};
      if (e == 1) res_ready1 = b ? ready4 : ready1;
      if (s_sclk != cpol && prev_sclk == cpol) begin
        res_mosi = {res_mosi[14:0], s_mosi};
        res_n_lead++;
        if (res_first_lead < 0) res_first_lead = e;
      end
      prev_sclk = s_sclk;
      if (s_cs != 4'hF) begin
        if (res_cs_first < 0) res_cs_first = e;
        res_cs_last = e;
        if (s_cs != cs_exp) res_cs_bad++;
      end
      if (b ? done4 : done1) begin
        res_n_done++;
        if (res_done_edge < 0) begin
          res_done_edge  = e;
          res_rd         = b ? rdata4 : rdata1;
          res_ready_done = b ? ready4 : ready1;
        end
      end
      if ((b ? rvalid4 : rvalid1) && res_rv_edge < 0) res_rv_edge = e;
      // MISO holds one bit per bit period: ones during rw/addr, then rd MSB first.
      k = (e - 1) / (2 * div);
      if (b) miso4 = (k < 8) ? 1'b1 : (k < 16) ? rd[15-k] : 1'b0;
      else   miso1 = (k < 8) ? 1'b1 : (k < 16) ? rd[15-k] : 1'b0;
    end
  endtask

  initial begin
    int err_done, err_cs, err_rdy;

    repeat (3) @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    chk("rst_ready", ready1, 1);
    chk("rst_done", done1, 0);
    chk("rst_rvalid", rvalid1, 0);
    chk("rst_err", err1, 0);
    chk("rst_rdata", rdata1, 8'h00);
    chk("rst_sclk", sclk1, 0);
    chk("rst_mosi", mosi1, 0);
    chk("rst_csn", cs_n1, 1);
    chk("rst_sclk_cpol1", sclk4, 1);
    chk("rst_csn4", cs_n4, 4'hF);

    // Read frame, addr 05, device returns 9E.
    rw1 = 1; addr1 = 7'h05; wdata1 = 8'h77; cs1 = 0;
    run_frame(0, 2, 0, 75, 8'h9E, -1);
    chk("rd_mosi_bits", res_mosi, 16'h8500);
    chk("rd_n_lead", res_n_lead, 16);
    chk("rd_done_edge", res_done_edge, 69);
    chk("rd_rvalid_edge", res_rv_edge, 69);
    chk("rd_rdata", res_rd, 8'h9E);
    chk("rd_n_done", res_n_done, 1);

    // Write frame, addr 2A, data C3; rdata must keep the read value.
    rw1 = 0; addr1 = 7'h2A; wdata1 = 8'hC3;
    run_frame(0, 2, 0, 75, 8'h00, -1);
    chk("wr_ready_e1", res_ready1, 0);
    chk("wr_mosi_bits", res_mosi, 16'h2AC3);
    chk("wr_first_lead", res_first_lead, 3);
    chk("wr_n_lead", res_n_lead, 16);
    chk("wr_cs_first", res_cs_first, 1);
    chk("wr_cs_last", res_cs_last, 66);
    chk("wr_done_edge", res_done_edge, 69);
    chk("wr_ready_done", res_ready_done, 1);
    chk("wr_rvalid_none", res_rv_edge, -1);
    chk("wr_rdata_held", rdata1, 8'h9E);

    // NUM_CS=4, CPOL=1, DIV=1, select 2.
    rw4 = 0; addr4 = 7'h11; wdata4 = 8'h5A; cs4 = 2;
    run_frame(1, 1, 2, 40, 8'h00, -1);
    chk("m4_mosi_bits", res_mosi, 16'h115A);
    chk("m4_first_lead", res_first_lead, 2);
    chk("m4_cs_first", res_cs_first, 1);
    chk("m4_cs_last", res_cs_last, 33);
    chk("m4_cs_only_sel", res_cs_bad, 0);
    chk("m4_done_edge", res_done_edge, 35);
    chk("m4_sclk_idle", sclk4, 1);

    // Out-of-range select on the single-CS instance.
    @(negedge CLK);
    cs1 = 1; start1 = 1;
    @(negedge CLK);
    start1 = 0;
    chk("err_pulse", err1, 1);
    chk("err_ready", ready1, 1);
    chk("err_csn", cs_n1, 1);
    err_done = 0; err_cs = 0; err_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) chk("err_pulse_end", err1, 0);
      err_done += done1;
      if (cs_n1 != 1'b1) err_cs++;
      if (ready1 != 1'b1) err_rdy++;
    end
    chk("err_no_done", err_done, 0);
    chk("err_no_cs", err_cs, 0);
    chk("err_ready_held", err_rdy, 0);
    cs1 = 0;

    // Reset in the middle of a write frame.
    rw1 = 0; addr1 = 7'h33; wdata1 = 8'hA5;
    run_frame(0, 2, 0, 30, 8'h00, -1);
    chk("mid_in_frame", res_cs_last, 30);
    #1 RST_N = 0;
    #1;
    chk("mid_rst_csn", cs_n1, 1);
    chk("mid_rst_sclk", sclk1, 0);
    chk("mid_rst_mosi", mosi1, 0);
    chk("mid_rst_ready", ready1, 1);
    chk("mid_rst_rdata", rdata1, 8'h00);
    repeat (2) @(negedge CLK);
    chk("mid_rst_no_done", done1, 0);
    RST_N = 1;
    @(negedge CLK);

    // Fresh write after reset; a start pulse mid-frame must be ignored.
    rw1 = 0; addr1 = 7'h40; wdata1 = 8'h0F;
    run_frame(0, 2, 0, 75, 8'h00, 20);
    chk("post_mosi_bits", res_mosi, 16'h400F);
    chk("post_cs_last", res_cs_last, 66);
    chk("post_done_edge", res_done_edge, 69);
    chk("post_n_done", res_n_done, 1);
    chk("post_rvalid_none", res_rv_edge, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
